// File: rtl/pong_pkg.sv
// Shared constants, game state type and span helper for the pong renderer.
package pong_pkg;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;

  // Frame tick fires on the first blanking line, column 0.
  localparam logic [9:0] TICK_X = 10'd0;
  localparam logic [9:0] TICK_Y = 10'd480;

  // Dashed centre net: 4 pixels wide, straddling the middle column.
  localparam logic [9:0] NET_X0 = 10'(H_VIS / 2 - 2);
  localparam logic [9:0] NET_X1 = 10'(H_VIS / 2 + 1);

  localparam logic [3:0] COL_FG = 4'hF;
  localparam logic [3:0] COL_BG = 4'h0;

  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

  // True when lo <= p < lo+len; done in int so lo+len cannot wrap.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo, input int len);
    return (int'(p) >= int'(lo)) && (int'(p) < int'(lo) + len);
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position moved by level buttons once per frame, clamped to the screen.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PAD_H     = 64,
  parameter int PAD_SPEED = 4,
  parameter int INIT_Y    = 208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       up,
  input  logic       dn,
  input  logic       freeze,
  output logic [9:0] y
);

  localparam logic [9:0] Y_MAX  = 10'(V_VIS - PAD_H);
  localparam logic [9:0] SPD    = 10'(PAD_SPEED);
  localparam logic [9:0] Y_INIT = 10'(INIT_Y);

  // Step on frame tick; compare before subtract/add so the paddle never wraps or leaves the screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= Y_INIT;
    end else if (tick && !freeze) begin
      if (up && !dn)
        y <= (y < SPD) ? '0 : y - SPD;
      else if (dn && !up)
        y <= (y > Y_MAX - SPD) ? Y_MAX : y + SPD;
    end
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong game state (ball, paddles, scores, FSM) and per-pixel colour for the VGA scan.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_X       = 16,
  parameter int PAD_SPEED   = 4,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       up_l,
  input  logic       dn_l,
  input  logic       up_r,
  input  logic       dn_r,
  input  logic       start,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  localparam logic [9:0] BS     = 10'(BALL_SIZE);
  localparam logic [9:0] SPD    = 10'(BALL_SPEED);
  localparam logic [9:0] PH     = 10'(PAD_H);
  localparam logic [9:0] HV     = 10'(H_VIS);
  localparam logic [9:0] VV     = 10'(V_VIS);
  localparam logic [9:0] CX     = 10'((H_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] CY     = 10'((V_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] BOT    = 10'(V_VIS - BALL_SIZE);
  localparam logic [9:0] PL_X   = 10'(PAD_X);
  localparam logic [9:0] PR_X   = 10'(H_VIS - PAD_X - PAD_W);
  localparam logic [9:0] FACE_L = 10'(PAD_X + PAD_W);
  localparam logic [9:0] FACE_R = PR_X;
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam int         CW     = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [9:0]    bx, by;
  logic          dx_pos, dy_pos;
  logic [9:0]    pl_y, pr_y;
  logic          frame_tick;

  assign frame_tick = (x == TICK_X) && (y == TICK_Y);

  pong_paddle #(.PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED), .INIT_Y((V_VIS - PAD_H) / 2)) u_pad_l (
    .clk(clk), .reset(reset), .tick(frame_tick), .up(up_l), .dn(dn_l),
    .freeze(state == OVER), .y(pl_y)
  );

  pong_paddle #(.PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED), .INIT_Y((V_VIS - PAD_H) / 2)) u_pad_r (
    .clk(clk), .reset(reset), .tick(frame_tick), .up(up_r), .dn(dn_r),
    .freeze(state == OVER), .y(pr_y)
  );

  function automatic logic v_overlap(input logic [9:0] b, input logic [9:0] p);
    return (b + BS > p) && (b < p + PH);
  endfunction

  logic [9:0] nbx, nby;
  logic       ndx, ndy, miss_l, miss_r;

  // Next ball position for one PLAY frame: step, then walls, paddle faces, misses.
  // Every condition uses the pre-step position; paddle faces are checked before misses.
  always_comb begin
    ndy    = dy_pos;
    ndx    = dx_pos;
    miss_l = 1'b0;
    miss_r = 1'b0;
    nbx    = bx;
    if (!dy_pos && by < SPD) begin
      nby = '0;
      ndy = 1'b1;
    end else if (dy_pos && (by + BS + SPD > VV)) begin
      nby = BOT;
      ndy = 1'b0;
    end else begin
      nby = dy_pos ? by + SPD : by - SPD;
    end
    if (!dx_pos && bx >= FACE_L && bx < FACE_L + SPD && v_overlap(by, pl_y)) begin
      nbx = FACE_L;
      ndx = 1'b1;
    end else if (dx_pos && (bx + BS <= FACE_R) && (bx + BS + SPD > FACE_R) && v_overlap(by, pr_y)) begin
      nbx = FACE_R - BS;
      ndx = 1'b0;
    end else if (!dx_pos && bx < SPD) begin
      miss_l = 1'b1;
    end else if (dx_pos && (bx + BS + SPD > HV)) begin
      miss_r = 1'b1;
    end else begin
      nbx = dx_pos ? bx + SPD : bx - SPD;
    end
  end

  // Game FSM, ball and scores; restart from OVER is taken on any cycle, everything else on frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SERVE;
      cnt     <= '0;
      bx      <= CX;
      by      <= CY;
      dx_pos  <= 1'b1;
      dy_pos  <= 1'b1;
      score_l <= '0;
      score_r <= '0;
    end else if (state == OVER) begin
      if (start) begin
        score_l <= '0;
        score_r <= '0;
        bx      <= CX;
        by      <= CY;
        cnt     <= '0;
        state   <= SERVE;
      end
    end else if (frame_tick) begin
      case (state)
        SERVE: begin
          bx <= CX;
          by <= CY;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= PLAY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLAY: begin
          if (miss_l || miss_r) begin
            // Recentre and serve toward the player who just conceded.
            bx     <= CX;
            by     <= CY;
            dx_pos <= miss_r;
            cnt    <= '0;
            if (miss_l) begin
              score_r <= (score_r == WIN) ? score_r : score_r + 1'b1;
              state   <= (4'(score_r + 4'd1) == WIN) ? OVER : SERVE;
            end else begin
              score_l <= (score_l == WIN) ? score_l : score_l + 1'b1;
              state   <= (4'(score_l + 4'd1) == WIN) ? OVER : SERVE;
            end
          end else begin
            bx     <= nbx;
            by     <= nby;
            dx_pos <= ndx;
            dy_pos <= ndy;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  logic visible, ball_on, pad_on, net_on, lit;

  // Which object, if any, covers the current scan position.
  always_comb begin
    visible = (x < HV) && (y < VV);
    ball_on = (state != OVER) && in_span(x, bx, BALL_SIZE) && in_span(y, by, BALL_SIZE);
    pad_on  = (in_span(x, PL_X, PAD_W) && in_span(y, pl_y, PAD_H)) ||
              (in_span(x, PR_X, PAD_W) && in_span(y, pr_y, PAD_H));
    net_on  = (x >= NET_X0) && (x <= NET_X1) && !y[4];
    lit     = visible && (ball_on || pad_on || net_on);
  end

  // Registered colour: one clock behind x/y, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red   <= COL_BG;
      green <= COL_BG;
      blue  <= COL_BG;
    end else begin
      red   <= lit ? COL_FG : COL_BG;
      green <= lit ? COL_FG : COL_BG;
      blue  <= lit ? COL_FG : COL_BG;
    end
  end

endmodule
